sram_bank_arb: RTL and testbench

//  Shares the banked tech_regfile_bm SRAM array (SRAM_BLOCK_SIZE banks) between NUM_REQ native requesters.

---
 rtl/sram_arb_pkg.sv | 35 +++
 rtl/sram_rr_arb.sv | 34 +++
 rtl/sram_bank_arb.sv | 148 ++++++++++++++
 tb/tb_sram_bank_arb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the banked SRAM arbiter.
//   wa_w/bk_w/addr_w : derive word-address, bank-select and full address widths
//   sram_req_t       : one requester access at the default geometry (64b x 512 x 4 banks)
//   bank_lock_t      : per-bank burst lock state (valid + owning requester index)
package sram_arb_pkg;

  localparam int unsigned LOCK_OWN_W  = 8;
  localparam int unsigned DEF_BW      = 64;
  localparam int unsigned DEF_ADDR_W  = 11;

  function automatic int unsigned wa_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned bk_w(input int unsigned blocks);
    return $clog2(blocks);
  endfunction

  function automatic int unsigned addr_w(input int unsigned depth, input int unsigned blocks);
    return $clog2(depth) + $clog2(blocks);
  endfunction

  typedef struct packed {
    logic                    wen;
    logic [DEF_ADDR_W-1:0]   addr;
    logic [DEF_BW/8-1:0]     bm;
    logic [DEF_BW-1:0]       wdata;
  } sram_req_t;

  typedef struct packed {
    logic                  vld;
    logic [LOCK_OWN_W-1:0] owner;
  } bank_lock_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Combinational round-robin pick among N requesters.
//   req : request vector
//   ptr : index of the previous winner; search starts at ptr+1 and wraps
//   gnt : one-hot grant
//   idx : index of the granted requester (0 when none)
//   vld : any grant issued
module sram_rr_arb #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    logic [IDX_W-1:0] j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = IDX_W'((32'(ptr) + k) % N);
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/sram_bank_arb.sv
// Shares a banked register-file SRAM between NUM_REQ requesters with
// independent round-robin arbitration per bank; requesters on different banks
// proceed in the same cycle. Bank pins are driven directly.
//   aclk/aresetn        clock, async active-low reset
//   req_*_i/req_ready_o requester access channel (ready = granted this cycle)
//   rsp_valid_o/rdata_o read response, one cycle after the grant
//   bank_*_o/bank_dat_i bank macro pins (active-low enables, data valid next cycle)
// Optional: define SRAM_ARB_LOCK_EN to honour req_lock_i as a per-bank burst lock;
// otherwise req_lock_i is ignored.
module sram_bank_arb
  import sram_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ         = 2,
  parameter  int unsigned SRAM_BIT_WIDTH  = 64,
  parameter  int unsigned SRAM_WORD_DEPTH = 512,
  parameter  int unsigned SRAM_BLOCK_SIZE = 4,
  localparam int unsigned WA_W   = wa_w(SRAM_WORD_DEPTH),
  localparam int unsigned BK_W   = bk_w(SRAM_BLOCK_SIZE),
  localparam int unsigned ADDR_W = addr_w(SRAM_WORD_DEPTH, SRAM_BLOCK_SIZE),
  localparam int unsigned BM_W   = SRAM_BIT_WIDTH / 8
) (
  input  logic                                          aclk,
  input  logic                                          aresetn,
  input  logic [NUM_REQ-1:0]                            req_valid_i,
  output logic [NUM_REQ-1:0]                            req_ready_o,
  input  logic [NUM_REQ-1:0]                            req_wen_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]                req_addr_i,
  input  logic [NUM_REQ-1:0][BM_W-1:0]                  req_bm_i,
  input  logic [NUM_REQ-1:0][SRAM_BIT_WIDTH-1:0]        req_wdata_i,
  input  logic [NUM_REQ-1:0]                            req_lock_i,
  output logic [NUM_REQ-1:0]                            rsp_valid_o,
  output logic [NUM_REQ-1:0][SRAM_BIT_WIDTH-1:0]        rsp_rdata_o,
  output logic [SRAM_BLOCK_SIZE-1:0]                    bank_en_n_o,
  output logic [SRAM_BLOCK_SIZE-1:0]                    bank_wen_n_o,
  output logic [SRAM_BLOCK_SIZE-1:0][BM_W-1:0]          bank_bm_o,
  output logic [SRAM_BLOCK_SIZE-1:0][WA_W-1:0]          bank_addr_o,
  output logic [SRAM_BLOCK_SIZE-1:0][SRAM_BIT_WIDTH-1:0] bank_dat_o,
  input  logic [SRAM_BLOCK_SIZE-1:0][SRAM_BIT_WIDTH-1:0] bank_dat_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           bank_gnt [SRAM_BLOCK_SIZE];
  logic [NUM_REQ-1:0]           rsp_valid_q;
  logic [NUM_REQ-1:0][BK_W-1:0] rd_bank_q;

`ifndef SRAM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
`endif

  for (genvar b = 0; b < SRAM_BLOCK_SIZE; b++) begin : g_bank
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               vld;

    // Gating with aresetn keeps the bank pins idle while reset is held.
    always_comb begin
      cand = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
        cand[i] = aresetn && req_valid_i[i] && (req_addr_i[i][ADDR_W-1:WA_W] == BK_W'(b));
    end

`ifdef SRAM_ARB_LOCK_EN
    bank_lock_t         lock_q;
    logic [NUM_REQ-1:0] own_mask;
    logic               hold;

    always_comb begin
      own_mask = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
        own_mask[i] = lock_q.vld && (lock_q.owner == LOCK_OWN_W'(i));
    end

    // Lock only restricts the pick while the owner still asserts req_lock_i;
    // the cycle it drops, arbitration is plain round-robin and the lock clears.
    assign hold = |(own_mask & req_lock_i);
    assign elig = hold ? (cand & own_mask) : cand;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        lock_q <= '0;
      end else if (vld && |(gnt & req_lock_i)) begin
        lock_q.vld   <= 1'b1;
        lock_q.owner <= LOCK_OWN_W'(idx);
      end else if (lock_q.vld && !hold) begin
        lock_q.vld <= 1'b0;
      end
    end
`else
    assign elig = cand;
`endif

    sram_rr_arb #(.N(NUM_REQ)) u_rr (
      .req (elig),
      .ptr (rr_ptr_q),
      .gnt (gnt),
      .idx (idx),
      .vld (vld)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
        rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      else if (vld)
        rr_ptr_q <= idx;
    end

    assign bank_gnt[b]     = gnt;
    assign bank_en_n_o[b]  = ~vld;
    assign bank_wen_n_o[b] = ~(vld && req_wen_i[idx]);
    assign bank_bm_o[b]    = vld ? req_bm_i[idx] : '0;
    assign bank_addr_o[b]  = vld ? req_addr_i[idx][WA_W-1:0] : '0;
    assign bank_dat_o[b]   = vld ? req_wdata_i[idx] : '0;
  end

  // Each requester addresses a single bank, so at most one bank grants it.
  always_comb begin
    req_ready_o = '0;
    for (int unsigned b = 0; b < SRAM_BLOCK_SIZE; b++)
      req_ready_o |= bank_gnt[b];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rsp_valid_q <= '0;
      rd_bank_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        rsp_valid_q[i] <= req_ready_o[i] && !req_wen_i[i];
        if (req_ready_o[i] && !req_wen_i[i])
          rd_bank_q[i] <= req_addr_i[i][ADDR_W-1:WA_W];
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;

  always_comb begin
    rsp_rdata_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      rsp_rdata_o[i] = bank_dat_i[rd_bank_q[i]];
  end

endmodule

// File: tb/tb_sram_bank_arb.sv
module tb_sram_bank_arb;

  localparam int NR  = 2;
  localparam int BW  = 64;
  localparam int DEP = 512;
  localparam int BLK = 4;
  localparam int WA  = 9;
  localparam int AW  = 11;
  localparam int BMW = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NR-1:0]            req_valid, req_ready, req_wen, req_lock, rsp_valid;
  logic [NR-1:0][AW-1:0]    req_addr;
  logic [NR-1:0][BMW-1:0]   req_bm;
  logic [NR-1:0][BW-1:0]    req_wdata, rsp_rdata;
  logic [BLK-1:0]           bank_en_n, bank_wen_n;
  logic [BLK-1:0][BMW-1:0]  bank_bm;
  logic [BLK-1:0][WA-1:0]   bank_addr;
  logic [BLK-1:0][BW-1:0]   bank_dat_o, bank_dat_i;

  always #5 aclk = ~aclk;

  sram_bank_arb #(
    .NUM_REQ(NR), .SRAM_BIT_WIDTH(BW), .SRAM_WORD_DEPTH(DEP), .SRAM_BLOCK_SIZE(BLK)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_bm_i(req_bm), .req_wdata_i(req_wdata),
    .req_lock_i(req_lock), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .bank_en_n_o(bank_en_n), .bank_wen_n_o(bank_wen_n), .bank_bm_o(bank_bm),
    .bank_addr_o(bank_addr), .bank_dat_o(bank_dat_o), .bank_dat_i(bank_dat_i)
  );

  // SRAM stub (environment) and reference model state
  logic [BW-1:0]  sram    [BLK][DEP];
  logic [BW-1:0]  ref_mem [BLK][DEP];
  logic           s_en  [BLK];
  logic           s_wen [BLK];
  logic [BMW-1:0] s_bm  [BLK];
  logic [WA-1:0]  s_addr[BLK];
  logic [BW-1:0]  s_dat [BLK];

  int            m_last [BLK];
  bit            m_lkv  [BLK];
  int            m_lko  [BLK];
  logic [NR-1:0] m_rv;
  logic [BW-1:0] m_rd [NR];
  logic [NR-1:0] exp_rdy;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [BW-1:0] pat(input int b, input int w);
    return {16'hA5A5, 16'(b), 32'(w)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < BLK; b++) begin
      m_last[b] = NR - 1;
      m_lkv[b]  = 1'b0;
      m_lko[b]  = 0;
    end
    m_rv = '0;
  endtask

  task automatic set_req(input int i, input bit v, input bit w, input int a,
                         input int bm, input logic [BW-1:0] d, input bit lk);
    req_valid[i] = v;
    req_wen[i]   = w;
    req_addr[i]  = AW'(a);
    req_bm[i]    = BMW'(bm);
    req_wdata[i] = d;
    req_lock[i]  = lk;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 0, 0, 0, 0, '0, 0);
  endtask

  // Negedge: snapshot bank pins for the SRAM stub, check outputs, advance model.
  task automatic at_neg();
    logic [NR-1:0]  cand, erdy, nrv;
    logic [BW-1:0]  nrd [NR];
    logic           e_en_n, e_wen_n;
    logic [BMW-1:0] e_bm;
    logic [WA-1:0]  e_addr;
    logic [BW-1:0]  e_dat;
    int win, j, w;
    @(negedge aclk);
    vectors++;
    if (!aresetn) model_reset();
    for (int b = 0; b < BLK; b++) begin
      s_en[b]   = ~bank_en_n[b];
      s_wen[b]  = ~bank_wen_n[b];
      s_bm[b]   = bank_bm[b];
      s_addr[b] = bank_addr[b];
      s_dat[b]  = bank_dat_o[b];
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    for (int i = 0; i < NR; i++)
      if (m_rv[i]) chk($sformatf("rsp_rdata%0d", i), rsp_rdata[i], m_rd[i]);
    erdy = '0;
    nrv  = '0;
    for (int i = 0; i < NR; i++) nrd[i] = '0;
    for (int b = 0; b < BLK; b++) begin
      cand = '0;
      if (aresetn)
        for (int i = 0; i < NR; i++)
          if (req_valid[i] && int'(req_addr[i][AW-1:WA]) == b) cand[i] = 1'b1;
`ifdef SRAM_ARB_LOCK_EN
      if (m_lkv[b] && req_lock[m_lko[b]])
        for (int i = 0; i < NR; i++) if (i != m_lko[b]) cand[i] = 1'b0;
`endif
      win = -1;
      for (int k = 1; k <= NR; k++) begin
        j = (m_last[b] + k) % NR;
        if (win < 0 && cand[j]) win = j;
      end
      if (win < 0) begin
        e_en_n = 1'b1; e_wen_n = 1'b1; e_bm = '0; e_addr = '0; e_dat = '0;
      end else begin
        e_en_n  = 1'b0;
        e_wen_n = ~req_wen[win];
        e_bm    = req_bm[win];
        e_addr  = req_addr[win][WA-1:0];
        e_dat   = req_wdata[win];
      end
      chk($sformatf("bank%0d_en_n", b),  64'(bank_en_n[b]),  64'(e_en_n));
      chk($sformatf("bank%0d_wen_n", b), 64'(bank_wen_n[b]), 64'(e_wen_n));
      chk($sformatf("bank%0d_bm", b),    64'(bank_bm[b]),    64'(e_bm));
      chk($sformatf("bank%0d_addr", b),  64'(bank_addr[b]),  64'(e_addr));
      chk($sformatf("bank%0d_dat", b),   bank_dat_o[b],      e_dat);
      if (win >= 0) begin
        erdy[win] = 1'b1;
        m_last[b] = win;
        w = int'(req_addr[win][WA-1:0]);
        if (req_wen[win]) begin
          for (int by = 0; by < BMW; by++)
            if (req_bm[win][by]) ref_mem[b][w][8*by +: 8] = req_wdata[win][8*by +: 8];
        end else begin
          nrv[win] = 1'b1;
          nrd[win] = ref_mem[b][w];
        end
      end
`ifdef SRAM_ARB_LOCK_EN
      if (aresetn) begin
        if (win >= 0 && req_lock[win]) begin
          m_lkv[b] = 1'b1;
          m_lko[b] = win;
        end else if (m_lkv[b] && !req_lock[m_lko[b]]) begin
          m_lkv[b] = 1'b0;
        end
      end
`endif
    end
    chk("req_ready", 64'(req_ready), 64'(erdy));
    m_rv = nrv;
    for (int i = 0; i < NR; i++) m_rd[i] = nrd[i];
    exp_rdy = erdy;
  endtask

  // Posedge: SRAM stub commits writes / launches reads, then inputs may change.
  task automatic to_next();
    @(posedge aclk);
    for (int b = 0; b < BLK; b++) begin
      if (s_en[b]) begin
        if (s_wen[b]) begin
          for (int by = 0; by < BMW; by++)
            if (s_bm[b][by]) sram[b][s_addr[b]][8*by +: 8] = s_dat[b][8*by +: 8];
        end else begin
          bank_dat_i[b] = sram[b][s_addr[b]];
        end
      end
    end
    #1;
  endtask

  initial begin
    for (int b = 0; b < BLK; b++)
      for (int w = 0; w < DEP; w++) begin
        sram[b][w]    = pat(b, w);
        ref_mem[b][w] = pat(b, w);
      end
    for (int b = 0; b < BLK; b++) begin
      s_en[b] = 1'b0; s_wen[b] = 1'b0; s_bm[b] = '0; s_addr[b] = '0; s_dat[b] = '0;
    end
    bank_dat_i = '0;
    exp_rdy    = '0;
    idle_all();
    model_reset();
    aresetn = 1'b0;
    at_neg(); to_next();
    at_neg(); to_next();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_en_n", 64'(bank_en_n), 64'hF);
    aresetn = 1'b1;

    // 1: single read, bank0 word 5
    set_req(0, 1, 0, 'h005, 0, '0, 0);
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    chk("t1_en_n", 64'(bank_en_n), 64'hE);
    chk("t1_addr", 64'(bank_addr[0]), 64'h5);
    at_neg(); to_next();
    idle_all();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rdata", rsp_rdata[0], 64'hA5A5_0000_0000_0005);

    // 2: both requesters on bank1, grants alternate
    set_req(0, 1, 0, 'h201, 0, '0, 0);
    set_req(1, 1, 0, 'h242, 0, '0, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t2_ready_c%0d", c), 64'(req_ready), (c % 2) ? 64'h2 : 64'h1);
      at_neg(); to_next();
    end
    idle_all();

    // 3: distinct banks granted together
    set_req(0, 1, 0, 'h010, 0, '0, 0);
    set_req(1, 1, 0, 'h210, 0, '0, 0);
    #1;
    chk("t3_ready", 64'(req_ready), 64'h3);
    at_neg(); to_next();
    idle_all();
    chk("t3_rsp_valid", 64'(rsp_valid), 64'h3);
    chk("t3_rdata0", rsp_rdata[0], 64'hA5A5_0000_0000_0010);
    chk("t3_rdata1", rsp_rdata[1], 64'hA5A5_0001_0000_0010);

    // 4: masked write then read-back of the same word
    set_req(1, 1, 1, 'h7FF, 'h0F, 64'hDEAD_BEEF_0123_4567, 0);
    #1;
    chk("t4_wr_ready", 64'(req_ready), 64'h2);
    chk("t4_wen_n", 64'(bank_wen_n), 64'h7);
    at_neg(); to_next();
    set_req(1, 1, 0, 'h7FF, 0, '0, 0);
    #1;
    chk("t4_rd_ready", 64'(req_ready), 64'h2);
    at_neg(); to_next();
    idle_all();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t4_rdata", rsp_rdata[1], 64'hA5A5_0003_0123_4567);

`ifdef SRAM_ARB_LOCK_EN
    // 5: req0 holds bank2 for three grants, req1 gets it when the lock drops
    set_req(0, 1, 0, 'h400, 0, '0, 1);
    set_req(1, 1, 0, 'h401, 0, '0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("t5_locked_c%0d", c), 64'(req_ready), 64'h1);
      at_neg(); to_next();
    end
    req_lock[0] = 1'b0;
    #1;
    chk("t5_unlock_ready", 64'(req_ready), 64'h2);
    at_neg(); to_next();
    idle_all();
`endif

    // 6: reset right after a granted read drops the response and restores priority
    set_req(0, 1, 0, 'h003, 0, '0, 0);
    #1;
    chk("t6_ready", 64'(req_ready), 64'h1);
    at_neg();
    #2;
    aresetn = 1'b0;
    idle_all();
    to_next();
    chk("t6_rsp_dropped", 64'(rsp_valid), 64'h0);
    at_neg(); to_next();
    aresetn = 1'b1;
    chk("t6_rsp_after_rel", 64'(rsp_valid), 64'h0);
    set_req(0, 1, 0, 'h006, 0, '0, 0);
    set_req(1, 1, 0, 'h007, 0, '0, 0);
    #1;
    chk("t6_prio_req0", 64'(req_ready), 64'h1);
    at_neg(); to_next();
    idle_all();

    // Randomized traffic; requesters hold fields until granted
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && exp_rdy[i]) req_valid[i] = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(3) != 0) begin
          req_valid[i] = 1'b1;
          req_wen[i]   = 1'($urandom_range(1));
          req_addr[i]  = {2'($urandom_range(3)),
                          ($urandom_range(1) != 0) ? 9'($urandom_range(7)) : 9'($urandom_range(511))};
          req_bm[i]    = 8'($urandom);
          req_wdata[i] = {$urandom, $urandom};
        end
        req_lock[i] = ($urandom_range(3) != 0);
      end
      at_neg(); to_next();
    end
    idle_all();
    at_neg(); to_next();
    at_neg(); to_next();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
